// File: rtl/snake_step_scheduler_pkg.sv
// snake_step_scheduler_pkg: shared FSM states, game-status encodings and divider defaults.
package snake_step_scheduler_pkg;
    typedef enum logic [2:0] {S_IDLE, S_RUN, S_REQ, S_EVAL, S_PAUSE, S_OVER} state_t;
    localparam logic GAME_START = 1'b0;
    localparam logic GAME_OVER = 1'b1;
    localparam int BASE_DIV_DEF = 50000000;
    localparam int DIV_STEP_DEF = 5000000;
    localparam int MIN_DIV_DEF = 10000000;
    function automatic int step_div(input int level, input int base, input int step, input int min_div);
        return (base - level * step > min_div) ? base - level * step : min_div;
    endfunction
endpackage

// File: rtl/snake_step_scheduler_if.sv
// snake_step_scheduler_if: buttons, body-logic handshake and game status bundle.
interface snake_step_scheduler_if #(parameter int SCORE_W = 8);
    logic btn_start, btn_pause, move_done, is_crash, is_suicide, food_eaten;
    logic move_req, grow, game_status, paused;
    logic [SCORE_W-1:0] score;
    logic [2:0] level;
    modport master (
        input btn_start, btn_pause, move_done, is_crash, is_suicide, food_eaten,
        output move_req, grow, game_status, paused, score, level
    );
    modport slave (
        output btn_start, btn_pause, move_done, is_crash, is_suicide, food_eaten,
        input move_req, grow, game_status, paused, score, level
    );
endinterface

// File: rtl/snake_step_tick.sv
// snake_step_tick: level-dependent step divider emitting a one-cycle tick.
module snake_step_tick
    import snake_step_scheduler_pkg::*;
#(
    parameter int BASE_DIV = BASE_DIV_DEF,
    parameter int DIV_STEP = DIV_STEP_DEF,
    parameter int MIN_DIV = MIN_DIV_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_en,
    input  logic       i_clr,
    input  logic [2:0] i_level,
    output logic       o_tick
);
    localparam int CW = $clog2(BASE_DIV + 1);
    logic [CW-1:0] r_cnt, r_div, w_div;
    assign w_div = CW'(step_div(int'(i_level), BASE_DIV, DIV_STEP, MIN_DIV));
    assign o_tick = i_en && (r_cnt == r_div - 1'b1);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
            r_div <= CW'(step_div(0, BASE_DIV, DIV_STEP, MIN_DIV));
        end else begin
            r_div <= w_div;
            r_cnt <= (i_clr || o_tick) ? '0 : i_en ? r_cnt + 1'b1 : r_cnt;
        end
    end
endmodule

// File: rtl/snake_step_scheduler.sv
// snake_step_scheduler: game FSM issuing one handshaked move per step tick.
// Optional pause support is built when SNAKE_PAUSE_EN is defined.
module snake_step_scheduler
    import snake_step_scheduler_pkg::*;
#(
    parameter int BASE_DIV = BASE_DIV_DEF,
    parameter int DIV_STEP = DIV_STEP_DEF,
    parameter int MIN_DIV = MIN_DIV_DEF,
    parameter int FOOD_PER_LEVEL = 4,
    parameter int SCORE_W = 8,
    parameter int LEVEL_MAX = 7,
    parameter int DONE_TIMEOUT = 255
) (
    input logic clk,
    input logic rst,
    snake_step_scheduler_if.master bus
);
    localparam int FW = $clog2(FOOD_PER_LEVEL + 1);
    localparam int TW = $clog2(DONE_TIMEOUT + 1);
`ifdef SNAKE_PAUSE_EN
    localparam bit PAUSE_EN = 1'b1;
`else
    localparam bit PAUSE_EN = 1'b0;
`endif
    state_t r_state, w_next;
    logic r_move_req, r_grow, r_status, r_crash, r_suicide, r_food, r_pend;
    logic [SCORE_W-1:0] r_score;
    logic [2:0] r_level;
    logic [FW-1:0] r_fcnt;
    logic [TW-1:0] r_to;
    logic w_tick, w_btn_pause, w_pause_req, w_en, w_clr, w_death, w_eat, w_clear, w_lvl_up;
    assign w_btn_pause = PAUSE_EN && bus.btn_pause;
    // a pause pressed during REQ/EVAL is held in r_pend and taken on the first RUN cycle
    assign w_pause_req = w_btn_pause || r_pend;
    assign w_en = (r_state == S_RUN) && !w_pause_req;
    assign w_clr = !(r_state == S_RUN || r_state == S_PAUSE);
    assign w_death = r_crash || r_suicide;
    assign w_eat = (r_state == S_EVAL) && r_food && !w_death;
    assign w_lvl_up = r_fcnt == FW'(FOOD_PER_LEVEL - 1);
    assign w_clear = (r_state == S_OVER) && bus.btn_start;
    assign bus.move_req = r_move_req;
    assign bus.grow = r_grow;
    assign bus.game_status = r_status;
    assign bus.paused = PAUSE_EN && (r_state == S_PAUSE);
    assign bus.score = r_score;
    assign bus.level = r_level;
    snake_step_tick #(
        .BASE_DIV(BASE_DIV),
        .DIV_STEP(DIV_STEP),
        .MIN_DIV (MIN_DIV)
    ) u_tick (
        .clk    (clk),
        .rst    (rst),
        .i_en   (w_en),
        .i_clr  (w_clr),
        .i_level(r_level),
        .o_tick (w_tick)
    );
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = bus.btn_start ? S_RUN : S_IDLE;
            S_RUN:   w_next = w_pause_req ? S_PAUSE : w_tick ? S_REQ : S_RUN;
            S_REQ:   w_next = bus.move_done ? S_EVAL : (r_to == TW'(DONE_TIMEOUT - 1)) ? S_OVER : S_REQ;
            S_EVAL:  w_next = w_death ? S_OVER : S_RUN;
            S_PAUSE: w_next = w_btn_pause ? S_RUN : S_PAUSE;
            S_OVER:  w_next = bus.btn_start ? S_IDLE : S_OVER;
            default: w_next = S_IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_move_req <= 1'b0;
            r_grow <= 1'b0;
            r_status <= GAME_START;
            r_crash <= 1'b0;
            r_suicide <= 1'b0;
            r_food <= 1'b0;
            r_pend <= 1'b0;
            r_score <= '0;
            r_level <= '0;
            r_fcnt <= '0;
            r_to <= '0;
        end else begin
            r_move_req <= (w_next == S_REQ);
            r_status <= (w_next == S_OVER) ? GAME_OVER : GAME_START;
            r_grow <= w_eat;
            r_to <= (r_state == S_REQ) ? r_to + 1'b1 : '0;
            r_pend <= (r_state == S_REQ || r_state == S_EVAL) && (r_pend || w_btn_pause);
            if (r_state == S_REQ && bus.move_done) begin
                r_crash <= bus.is_crash;
                r_suicide <= bus.is_suicide;
                r_food <= bus.food_eaten;
            end
            if (w_clear) begin
                r_score <= '0;
                r_level <= '0;
                r_fcnt <= '0;
            end else if (w_eat) begin
                r_score <= &r_score ? r_score : r_score + 1'b1;
                r_fcnt <= w_lvl_up ? '0 : r_fcnt + 1'b1;
                if (w_lvl_up) r_level <= (r_level == 3'(LEVEL_MAX)) ? r_level : r_level + 3'd1;
            end
        end
    end
endmodule
